// File: rtl/bus_rr_arbiter.sv
// rtl/bus_rr_arbiter.sv - round-robin owner arbiter driving the mux16to1 select with bounded hold and turnaround
module bus_rr_arbiter #(
    parameter int N_REQ    = 16,
    parameter int SEL_W    = 5,
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             arb_en,
    output logic [N_REQ-1:0] grant,
    output logic [SEL_W-1:0] fn_sel,
    output logic             bus_valid,
    output logic             preempt
);

    localparam int IDX_W  = $clog2(N_REQ);
    localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_TURN
    } state_t;

    state_t            state;
    logic [IDX_W-1:0]  ptr;
    logic [IDX_W-1:0]  owner;
    logic [HOLD_W-1:0] hold_cnt;

    logic [IDX_W-1:0]  cand;
    logic [IDX_W-1:0]  winner;
    logic              found;
    logic              others_wait;
    logic              release_now;

    // Rotating search starting at ptr; the 4-bit add wraps 15 back to 0.
    always_comb begin
        cand   = '0;
        winner = '0;
        found  = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = ptr + IDX_W'(k);
            if (!found && req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    // grant holds exactly the owner bit while in GRANT, so masking it leaves only waiters.
    assign others_wait = |(req & ~grant);
    assign release_now = !req[owner] || ((hold_cnt == HOLD_LAST) && others_wait);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            ptr       <= '0;
            owner     <= '0;
            hold_cnt  <= '0;
            grant     <= '0;
            fn_sel    <= '0;
            bus_valid <= 1'b0;
            preempt   <= 1'b0;
        end else begin
            preempt <= 1'b0;
            case (state)
                S_IDLE, S_TURN: begin
                    if (arb_en && found) begin
                        state     <= S_GRANT;
                        owner     <= winner;
                        hold_cnt  <= '0;
                        grant     <= N_REQ'(1) << winner;
                        fn_sel    <= SEL_W'(winner);
                        bus_valid <= 1'b1;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_GRANT: begin
                    if (release_now) begin
                        // Owner still requesting here means it was forced off the bus.
                        state     <= S_TURN;
                        preempt   <= req[owner];
                        ptr       <= owner + 1'b1;
                        grant     <= '0;
                        fn_sel    <= '0;
                        bus_valid <= 1'b0;
                    end else if (hold_cnt != HOLD_LAST) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    grant     <= '0;
                    fn_sel    <= '0;
                    bus_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// tb/tb_bus_rr_arbiter.sv - scoreboard bench for bus_rr_arbiter
module tb_bus_rr_arbiter;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic        clk;
    logic        rst;
    logic [15:0] req;
    logic        arb_en;
    logic [15:0] grant;
    logic [4:0]  fn_sel;
    logic        bus_valid;
    logic        preempt;

    int total = 0;
    int bad   = 0;
    logic mon_on = 1'b0;
    logic [15:0] prev_grant = '0;
    logic [16:0] exp_q[$];

    typedef struct packed {
        logic        rs;
        logic        en;
        logic [15:0] rq;
        logic [15:0] g;
        logic        p;
    } row_t;

    bus_rr_arbiter #(.N_REQ(16), .SEL_W(5), .MAX_HOLD(4)) dut (
        .clk(clk), .rst(rst), .req(req), .arb_en(arb_en),
        .grant(grant), .fn_sel(fn_sel), .bus_valid(bus_valid), .preempt(preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic row_t mk(input logic rs, input logic en, input logic [15:0] rq,
                                input logic [15:0] g, input logic p);
        mk = '{rs: rs, en: en, rq: rq, g: g, p: p};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Per-cycle invariants and the turnaround rule.
    always @(negedge clk) begin
        if (mon_on) begin
            logic [4:0] idx;
            idx = '0;
            for (int i = 0; i < 16; i++) if (grant[i]) idx = 5'(i);
            total++;
            if ($countones(grant) > 1 || bus_valid !== (|grant) || fn_sel !== idx) begin
                bad++;
                $display("FAIL invariant grant=%h bus_valid=%b fn_sel=%0d want_fn_sel=%0d", grant, bus_valid, fn_sel, idx);
            end
            total++;
            if (prev_grant != 0 && grant != 0 && grant !== prev_grant) begin
                bad++;
                $display("FAIL no_turn prev_grant=%h grant=%h want=dead cycle", prev_grant, grant);
            end
            prev_grant = grant;
        end
    end

    task automatic test_reset();
        row_t rows[$];
        logic [16:0] e;
        rows = '{mk(H, H, 16'hFFFF, 16'h0000, L), mk(H, H, 16'hFFFF, 16'h0000, L),
                 mk(L, H, 16'h0000, 16'h0000, L)};
        foreach (rows[i]) begin
            rst = rows[i].rs; arb_en = rows[i].en; req = rows[i].rq;
            exp_q.push_back({rows[i].p, rows[i].g});
            tick();
            e = exp_q.pop_front();
            total++;
            if (grant !== e[15:0] || preempt !== e[16] || bus_valid !== (|e[15:0]) || fn_sel !== 5'd0) begin
                bad++;
                $display("FAIL reset[%0d] grant=%h pre=%b bv=%b fn_sel=%0d want grant=%h pre=%b fn_sel=0",
                         i, grant, preempt, bus_valid, fn_sel, e[15:0], e[16]);
            end
        end
    endtask

    task automatic test_single();
        row_t rows[$];
        logic [16:0] e;
        rows = '{mk(L, H, 16'h0020, 16'h0020, L), mk(L, H, 16'h0000, 16'h0000, L),
                 mk(L, H, 16'h0000, 16'h0000, L)};
        foreach (rows[i]) begin
            rst = rows[i].rs; arb_en = rows[i].en; req = rows[i].rq;
            exp_q.push_back({rows[i].p, rows[i].g});
            tick();
            e = exp_q.pop_front();
            total++;
            if (grant !== e[15:0] || preempt !== e[16] || bus_valid !== (|e[15:0])) begin
                bad++;
                $display("FAIL single[%0d] grant=%h pre=%b bv=%b want grant=%h pre=%b", i, grant, preempt, bus_valid, e[15:0], e[16]);
            end
            if (e[5]) begin
                total++;
                if (fn_sel !== 5'd5) begin
                    bad++;
                    $display("FAIL single_fn_sel fn_sel=%0d want=5", fn_sel);
                end
            end
        end
    endtask

    task automatic test_round_robin();
        row_t rows[$];
        logic [16:0] e;
        rows = '{mk(H, H, 16'h0000, 16'h0000, L),
                 mk(L, H, 16'h0088, 16'h0008, L), mk(L, H, 16'h0088, 16'h0008, L),
                 mk(L, H, 16'h0080, 16'h0000, L), mk(L, H, 16'h0088, 16'h0080, L),
                 mk(L, H, 16'h0088, 16'h0080, L), mk(L, H, 16'h0008, 16'h0000, L),
                 mk(L, H, 16'h0088, 16'h0008, L), mk(L, H, 16'h0088, 16'h0008, L),
                 mk(L, H, 16'h0080, 16'h0000, L), mk(L, H, 16'h0088, 16'h0080, L),
                 mk(L, H, 16'h0088, 16'h0080, L), mk(L, H, 16'h0008, 16'h0000, L),
                 mk(L, H, 16'h0000, 16'h0000, L)};
        foreach (rows[i]) begin
            rst = rows[i].rs; arb_en = rows[i].en; req = rows[i].rq;
            exp_q.push_back({rows[i].p, rows[i].g});
            tick();
            e = exp_q.pop_front();
            total++;
            if (grant !== e[15:0] || preempt !== e[16] || bus_valid !== (|e[15:0])) begin
                bad++;
                $display("FAIL round_robin[%0d] grant=%h pre=%b bv=%b want grant=%h pre=%b", i, grant, preempt, bus_valid, e[15:0], e[16]);
            end
        end
    endtask

    task automatic test_preempt();
        row_t rows[$];
        logic [16:0] e;
        rows = '{mk(L, H, 16'h0004, 16'h0004, L), mk(L, H, 16'h0204, 16'h0004, L),
                 mk(L, H, 16'h0204, 16'h0004, L), mk(L, H, 16'h0204, 16'h0004, L),
                 mk(L, H, 16'h0204, 16'h0000, H), mk(L, H, 16'h0204, 16'h0200, L),
                 mk(L, H, 16'h0004, 16'h0000, L)};
        for (int k = 0; k < 9; k++) rows.push_back(mk(L, H, 16'h0004, 16'h0004, L));
        rows.push_back(mk(L, H, 16'h0000, 16'h0000, L));
        rows.push_back(mk(L, H, 16'h0000, 16'h0000, L));
        foreach (rows[i]) begin
            rst = rows[i].rs; arb_en = rows[i].en; req = rows[i].rq;
            exp_q.push_back({rows[i].p, rows[i].g});
            tick();
            e = exp_q.pop_front();
            total++;
            if (grant !== e[15:0] || preempt !== e[16] || bus_valid !== (|e[15:0])) begin
                bad++;
                $display("FAIL preempt[%0d] grant=%h pre=%b bv=%b want grant=%h pre=%b", i, grant, preempt, bus_valid, e[15:0], e[16]);
            end
        end
    endtask

    task automatic test_arb_en();
        row_t rows[$];
        logic [16:0] e;
        rows = '{mk(L, L, 16'h0010, 16'h0000, L), mk(L, H, 16'h0010, 16'h0010, L),
                 mk(L, L, 16'h0030, 16'h0010, L), mk(L, L, 16'h0020, 16'h0000, L),
                 mk(L, L, 16'h0020, 16'h0000, L), mk(L, L, 16'h0020, 16'h0000, L),
                 mk(L, H, 16'h0020, 16'h0020, L), mk(L, L, 16'h0120, 16'h0020, L),
                 mk(L, L, 16'h0120, 16'h0020, L), mk(L, L, 16'h0120, 16'h0020, L),
                 mk(L, L, 16'h0120, 16'h0000, H), mk(L, L, 16'h0120, 16'h0000, L),
                 mk(L, H, 16'h0120, 16'h0100, L), mk(L, H, 16'h0000, 16'h0000, L),
                 mk(L, H, 16'h0000, 16'h0000, L)};
        foreach (rows[i]) begin
            rst = rows[i].rs; arb_en = rows[i].en; req = rows[i].rq;
            exp_q.push_back({rows[i].p, rows[i].g});
            tick();
            e = exp_q.pop_front();
            total++;
            if (grant !== e[15:0] || preempt !== e[16] || bus_valid !== (|e[15:0])) begin
                bad++;
                $display("FAIL arb_en[%0d] grant=%h pre=%b bv=%b want grant=%h pre=%b", i, grant, preempt, bus_valid, e[15:0], e[16]);
            end
        end
    endtask

    task automatic test_wrap();
        row_t rows[$];
        logic [16:0] e;
        rows = '{mk(L, H, 16'h8000, 16'h8000, L), mk(L, H, 16'h8001, 16'h8000, L),
                 mk(L, H, 16'h0001, 16'h0000, L), mk(L, H, 16'h8001, 16'h0001, L),
                 mk(L, H, 16'h8000, 16'h0000, L), mk(L, H, 16'h8000, 16'h8000, L),
                 mk(L, H, 16'h0000, 16'h0000, L), mk(L, H, 16'h0000, 16'h0000, L)};
        foreach (rows[i]) begin
            rst = rows[i].rs; arb_en = rows[i].en; req = rows[i].rq;
            exp_q.push_back({rows[i].p, rows[i].g});
            tick();
            e = exp_q.pop_front();
            total++;
            if (grant !== e[15:0] || preempt !== e[16] || bus_valid !== (|e[15:0])) begin
                bad++;
                $display("FAIL wrap[%0d] grant=%h pre=%b bv=%b want grant=%h pre=%b", i, grant, preempt, bus_valid, e[15:0], e[16]);
            end
        end
    endtask

    task automatic test_reset_mid();
        row_t rows[$];
        logic [16:0] e;
        rows = '{mk(L, H, 16'h0040, 16'h0040, L), mk(L, H, 16'h0000, 16'h0000, L),
                 mk(L, H, 16'h0040, 16'h0040, L), mk(H, H, 16'h0040, 16'h0000, L),
                 mk(L, H, 16'h0041, 16'h0001, L), mk(L, H, 16'h0000, 16'h0000, L),
                 mk(L, H, 16'h0000, 16'h0000, L)};
        foreach (rows[i]) begin
            rst = rows[i].rs; arb_en = rows[i].en; req = rows[i].rq;
            exp_q.push_back({rows[i].p, rows[i].g});
            tick();
            e = exp_q.pop_front();
            total++;
            if (grant !== e[15:0] || preempt !== e[16] || bus_valid !== (|e[15:0])) begin
                bad++;
                $display("FAIL reset_mid[%0d] grant=%h pre=%b bv=%b want grant=%h pre=%b", i, grant, preempt, bus_valid, e[15:0], e[16]);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        req = '0;
        arb_en = 1'b1;
        test_reset();
        mon_on = 1'b1;
        test_single();
        test_round_robin();
        test_preempt();
        test_arb_en();
        test_wrap();
        test_reset_mid();
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
